// File: rtl/vadd_axis_pkg.sv
// Shared types and geometry helpers for the vadd AXI4-Stream traffic checker.
package vadd_axis_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int lanes_f(input int tdata_w, input int adder_w);
      return tdata_w / adder_w;
   endfunction

   function automatic int nbeats_f(input int tdata_w, input int len_bytes);
      return len_bytes / (tdata_w / 8);
   endfunction

   function automatic int cnt_w_f(input int nbeats);
      return $clog2(nbeats) + 1;
   endfunction

endpackage

// File: rtl/vadd_axis_pattern_gen.sv
// Builds one full beat of the ramp pattern: lane j of beat k is k*LANES+j+offset,
// wrapping at the lane width.
module vadd_axis_pattern_gen
   import vadd_axis_pkg::*;
#(
   parameter int C_AXIS_TDATA_WIDTH = 512,
   parameter int C_ADDER_BIT_WIDTH  = 32,
   parameter int CNT_W              = 9
) (
   input  logic [CNT_W-1:0]              beat_idx,
   input  logic [C_ADDER_BIT_WIDTH-1:0]  offset,
   output logic [C_AXIS_TDATA_WIDTH-1:0] data
);

   localparam int AW    = C_ADDER_BIT_WIDTH;
   localparam int LANES = lanes_f(C_AXIS_TDATA_WIDTH, C_ADDER_BIT_WIDTH);

   logic [AW-1:0] base;

   assign base = AW'(beat_idx) * AW'(LANES);

   always_comb begin
      data = '0;
      for (int j = 0; j < LANES; j++) begin
         data[j*AW +: AW] = base + AW'(j) + offset;
      end
   end

endmodule

// File: rtl/vadd_axis_traffic_checker.sv
// Drives a ramp pattern into a vector adder over AXI4-Stream and checks the
// returned stream against ramp+constant, counting erroneous beats.
module vadd_axis_traffic_checker
   import vadd_axis_pkg::*;
#(
   parameter int          C_AXIS_TDATA_WIDTH = 512,
   parameter int          C_ADDER_BIT_WIDTH  = 32,
   parameter int          C_LENGTH_IN_BYTES  = 16384,
   parameter logic [15:0] C_TDEST            = 16'h0000
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic                            start,
   input  logic [31:0]                     ctrl_constant,
   output logic                            done,
   output logic                            pass,
   output logic [31:0]                     err_count,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                            m_axis_tlast,
   output logic [15:0]                     m_axis_tdest,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                            s_axis_tlast,
   input  logic [15:0]                     s_axis_tdest
);

   localparam int AW     = C_ADDER_BIT_WIDTH;
   localparam int NBEATS = nbeats_f(C_AXIS_TDATA_WIDTH, C_LENGTH_IN_BYTES);
   localparam int CW     = cnt_w_f(NBEATS);

   localparam logic [CW-1:0] NBEATS_C = CW'(NBEATS);
   localparam logic [CW-1:0] LAST_IDX = CW'(NBEATS - 1);

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   state_t                          state_q, state_d;
   logic [CW-1:0]                   tx_cnt, rx_cnt;
   logic                            tvalid_q;
   logic [31:0]                     err_q;
   logic [31:0]                     constant_q;
   logic [C_AXIS_TDATA_WIDTH-1:0]   exp_data;
   logic                            start_ok, tx_fire, rx_fire, rx_err;
   logic                            tdest_unused;

   assign start_ok = start && (state_q != RUN);
   assign tx_fire  = m_axis_tvalid && m_axis_tready;
   assign rx_fire  = s_axis_tvalid && s_axis_tready;
   assign rx_err   = (s_axis_tdata != exp_data) || (s_axis_tkeep != '1) ||
                     (s_axis_tlast != (rx_cnt == LAST_IDX));

   // The adder is free to return any tdest.
   assign tdest_unused = ^s_axis_tdest;

   vadd_axis_pattern_gen #(
      .C_AXIS_TDATA_WIDTH (C_AXIS_TDATA_WIDTH),
      .C_ADDER_BIT_WIDTH  (C_ADDER_BIT_WIDTH),
      .CNT_W              (CW)
   ) u_tx_gen (
      .beat_idx (tx_cnt),
      .offset   ('0),
      .data     (m_axis_tdata)
   );

   vadd_axis_pattern_gen #(
      .C_AXIS_TDATA_WIDTH (C_AXIS_TDATA_WIDTH),
      .C_ADDER_BIT_WIDTH  (C_ADDER_BIT_WIDTH),
      .CNT_W              (CW)
   ) u_rx_gen (
      .beat_idx (rx_cnt),
      .offset   (AW'(constant_q)),
      .data     (exp_data)
   );

   always_ff @(posedge aclk) begin
      if (areset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if ((tx_cnt == NBEATS_C) && (rx_cnt == NBEATS_C)) state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // tvalid is registered so it rises one cycle after entering RUN and falls
   // right after the final beat is accepted.
   always_ff @(posedge aclk) begin
      if (areset) begin
         tx_cnt   <= '0;
         rx_cnt   <= '0;
         tvalid_q <= 1'b0;
         err_q    <= '0;
      end else if (start_ok) begin
         tx_cnt   <= '0;
         rx_cnt   <= '0;
         tvalid_q <= 1'b0;
         err_q    <= '0;
      end else if (state_q == RUN) begin
         if (tx_fire) tx_cnt <= tx_cnt + CW'(1);
         tvalid_q <= (tx_cnt < NBEATS_C) && !(tx_fire && (tx_cnt == LAST_IDX));
         if (rx_fire) begin
            rx_cnt <= rx_cnt + CW'(1);
            if (rx_err) err_q <= sat_inc(err_q);
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (start_ok) constant_q <= ctrl_constant;
   end

   // Outputs are gated so they read zero for the whole time reset is held.
   assign m_axis_tvalid = tvalid_q && !areset;
   assign m_axis_tlast  = m_axis_tvalid && (tx_cnt == LAST_IDX);
   assign m_axis_tkeep  = '1;
   assign m_axis_tdest  = C_TDEST;
   assign s_axis_tready = !areset && (state_q == RUN) && (rx_cnt < NBEATS_C);
   assign done          = !areset && (state_q == DONE);
   assign pass          = done && (err_q == 32'd0);
   assign err_count     = areset ? 32'd0 : err_q;

endmodule

// File: tb/tb_vadd_axis_traffic_checker.sv
// Randomized loopback bench: a modelled adder sits between the checker's two
// streams, and a scoreboard checks every tx beat and every run result.
module tb_vadd_axis_traffic_checker;

   localparam int W     = 512;
   localparam int AW    = 32;
   localparam int LANES = W / AW;
   localparam int NB    = 16384 / (W / 8);

   logic          aclk;
   logic          areset;
   logic          start;
   logic [31:0]   ctrl_constant;
   logic          done, pass;
   logic [31:0]   err_count;
   logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic [W-1:0]  m_axis_tdata;
   logic [W/8-1:0] m_axis_tkeep;
   logic [15:0]   m_axis_tdest;
   logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [W-1:0]  s_axis_tdata;
   logic [W/8-1:0] s_axis_tkeep;
   logic [15:0]   s_axis_tdest;

   vadd_axis_traffic_checker #(
      .C_AXIS_TDATA_WIDTH (W),
      .C_ADDER_BIT_WIDTH  (AW),
      .C_LENGTH_IN_BYTES  (16384),
      .C_TDEST            (16'h0000)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .start         (start),
      .ctrl_constant (ctrl_constant),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tdest  (m_axis_tdest),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tdest  (s_axis_tdest)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_chk  = 0;
   int n_pass = 0;

   // scoreboard queues
   logic [W-1:0] tx_exp_d[$];
   logic         tx_exp_l[$];
   logic [32:0]  res_exp[$];

   // adder model state
   logic [W-1:0] af_d[$];
   logic         af_l[$];
   logic [31:0]  adder_add = 0;
   int           adder_idx = 0;
   bit           corrupt_beat[int];
   bit           tlast_force[int];
   bit           bp = 0;
   bit           flush_req = 0;

   int tx_seen = 0;
   int rx_seen = 0;
   bit done_seen = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [W-1:0] ramp_beat(input int k);
      logic [W-1:0] v;
      for (int j = 0; j < LANES; j++) v[j*AW +: AW] = 32'(k * LANES + j);
      return v;
   endfunction

   // Adder model: accepts tx beats, adds the constant (wrapping), optionally
   // corrupts selected beats, and returns them with its own backpressure.
   initial begin
      logic         tx_hs, rx_hs, tx_l, l;
      logic [W-1:0] tx_d, d;
      m_axis_tready = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '1;
      s_axis_tlast  = 1'b0;
      s_axis_tdest  = '0;
      forever begin
         @(negedge aclk);
         tx_hs = m_axis_tvalid && m_axis_tready;
         tx_d  = m_axis_tdata;
         tx_l  = m_axis_tlast;
         rx_hs = s_axis_tvalid && s_axis_tready;
         @(posedge aclk);
         #2;
         if (tx_hs) begin
            for (int j = 0; j < LANES; j++) d[j*AW +: AW] = tx_d[j*AW +: AW] + adder_add;
            l = tx_l;
            if (corrupt_beat.exists(adder_idx)) d[5*AW +: AW] = d[5*AW +: AW] ^ 32'h1;
            if (tlast_force.exists(adder_idx)) l = 1'b1;
            af_d.push_back(d);
            af_l.push_back(l);
            adder_idx++;
         end
         if (rx_hs) s_axis_tvalid = 1'b0;
         if (flush_req) begin
            af_d.delete();
            af_l.delete();
            s_axis_tvalid = 1'b0;
            adder_idx = 0;
            flush_req = 0;
         end
         if (!s_axis_tvalid && af_d.size() > 0 && (!bp || $urandom_range(1, 0) == 1)) begin
            s_axis_tdata  = af_d.pop_front();
            s_axis_tlast  = af_l.pop_front();
            s_axis_tdest  = 16'($urandom);
            s_axis_tvalid = 1'b1;
         end
         m_axis_tready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
      end
   end

   // Monitor: checks each tx beat, tx hold-under-stall, and each run result.
   initial begin
      logic         prev_stall, prev_l, done_prev;
      logic [W-1:0] prev_d;
      logic [32:0]  r;
      prev_stall = 0; prev_l = 0; prev_d = '0; done_prev = 0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            prev_stall = 0;
            done_prev  = 0;
         end else begin
            if (prev_stall) begin
               chk("tx_hold_valid", W'(m_axis_tvalid), W'(1));
               chk("tx_hold_data", m_axis_tdata, prev_d);
               chk("tx_hold_last", W'(m_axis_tlast), W'(prev_l));
            end
            if (m_axis_tvalid && m_axis_tready) begin
               chk("tx_beat_expected", W'(tx_exp_d.size() > 0), W'(1));
               if (tx_exp_d.size() > 0) begin
                  chk("tx_data", m_axis_tdata, tx_exp_d.pop_front());
                  chk("tx_last", W'(m_axis_tlast), W'(tx_exp_l.pop_front()));
               end
               tx_seen++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d     = m_axis_tdata;
            prev_l     = m_axis_tlast;
            if (s_axis_tvalid && s_axis_tready) rx_seen++;
            if (done && !done_prev) begin
               chk("done_expected", W'(res_exp.size() > 0), W'(1));
               if (res_exp.size() > 0) begin
                  r = res_exp.pop_front();
                  chk("err_count", W'(err_count), W'(r[31:0]));
                  chk("pass", W'(pass), W'(r[32]));
               end
               chk("tx_all_sent", W'(tx_exp_d.size()), W'(0));
               chk("rx_beats", W'(rx_seen), W'(NB));
               done_seen = 1;
            end
            done_prev = done;
         end
      end
   end

   task automatic start_run(input logic [31:0] c);
      int e;
      @(posedge aclk);
      #1;
      ctrl_constant = c;
      adder_add     = c;
      adder_idx     = 0;
      tx_seen       = 0;
      rx_seen       = 0;
      done_seen     = 0;
      for (int k = 0; k < NB; k++) begin
         tx_exp_d.push_back(ramp_beat(k));
         tx_exp_l.push_back(k == NB - 1);
      end
      e = 0;
      for (int rb = 0; rb < NB; rb++)
         if (corrupt_beat.exists(rb) || (tlast_force.exists(rb) && rb != NB - 1)) e++;
      res_exp.push_back({(e == 0), 32'(e)});
      start = 1'b1;
      @(posedge aclk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20000 && !done_seen; i++) @(negedge aclk);
      chk("done_reached", W'(done_seen), W'(1));
      @(negedge aclk);
      chk("tx_idle_after_done", W'(m_axis_tvalid), W'(0));
      chk("rx_idle_after_done", W'(s_axis_tready), W'(0));
      chk("done_held", W'(done), W'(1));
   endtask

   task automatic wait_tx(input int n);
      for (int i = 0; i < 20000 && tx_seen < n; i++) @(negedge aclk);
      chk("tx_progress", W'(tx_seen >= n), W'(1));
   endtask

   initial begin
      areset = 1'b1;
      start = 1'b0;
      ctrl_constant = '0;
      repeat (4) @(posedge aclk);
      @(negedge aclk);
      chk("rst_m_tvalid", W'(m_axis_tvalid), W'(0));
      chk("rst_m_tlast", W'(m_axis_tlast), W'(0));
      chk("rst_s_tready", W'(s_axis_tready), W'(0));
      chk("rst_done", W'(done), W'(0));
      chk("rst_pass", W'(pass), W'(0));
      chk("rst_err_count", W'(err_count), W'(0));
      @(posedge aclk);
      #1;
      areset = 1'b0;
      repeat (2) @(negedge aclk);
      chk("idle_m_tvalid", W'(m_axis_tvalid), W'(0));

      // clean loopback, full throughput
      bp = 0;
      start_run(32'd3);
      wait_done();

      // random backpressure on both sides, random constant
      bp = 1;
      start_run($urandom);
      wait_done();

      // lane 5 corrupted on rx beats 10 and 200
      corrupt_beat[10]  = 1;
      corrupt_beat[200] = 1;
      start_run(32'd3);
      wait_done();
      corrupt_beat.delete();

      // early tlast on rx beat 100, with wrapping lanes
      tlast_force[100] = 1;
      start_run(32'hFFFF_FFFF);
      wait_done();
      tlast_force.delete();

      // reset in the middle of a run, then a fresh clean run
      bp = 0;
      start_run(32'd3);
      wait_tx(50);
      @(posedge aclk);
      #1;
      areset = 1'b1;
      @(negedge aclk);
      chk("abort_m_tvalid", W'(m_axis_tvalid), W'(0));
      chk("abort_s_tready", W'(s_axis_tready), W'(0));
      @(posedge aclk);
      #1;
      tx_exp_d.delete();
      tx_exp_l.delete();
      res_exp.delete();
      flush_req = 1;
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b0;
      repeat (3) @(negedge aclk);
      chk("post_abort_m_tvalid", W'(m_axis_tvalid), W'(0));
      chk("post_abort_s_tready", W'(s_axis_tready), W'(0));
      chk("post_abort_done", W'(done), W'(0));
      bp = 1;
      start_run(32'd3);
      wait_done();

      // start pulsed mid-run with a different constant must be ignored
      start_run(32'd3);
      wait_tx(100);
      @(posedge aclk);
      #1;
      ctrl_constant = 32'd77;
      start = 1'b1;
      @(posedge aclk);
      #1;
      start = 1'b0;
      ctrl_constant = 32'd3;
      wait_done();

      @(negedge aclk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
